// File: rtl/i2c_init_sequencer_if.sv
// Transaction type shared with i2c_controller, plus the sequencer <-> controller bus.
package i2c_init_sequencer_pkg;
  typedef enum logic [0:0] {
    WRITE_8BIT_REGISTER = 1'b0,
    READ_8BIT           = 1'b1
  } i2c_transaction_t;
endpackage

// Command (ctl_*) and read-return (rd_*) channels between sequencer and controller.
interface i2c_init_sequencer_if;
  import i2c_init_sequencer_pkg::*;

  i2c_transaction_t ctl_mode;
  logic             ctl_valid;
  logic             ctl_ready;
  logic [6:0]       ctl_addr;
  logic [7:0]       ctl_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [7:0]       rd_data;

  modport master (
    output ctl_mode, ctl_valid, ctl_addr, ctl_data, rd_ready,
    input  ctl_ready, rd_valid, rd_data
  );

  modport slave (
    input  ctl_mode, ctl_valid, ctl_addr, ctl_data, rd_ready,
    output ctl_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/i2c_init_sequencer.sv
// ROM-driven I2C bring-up sequencer: writes, delays and read-and-verify polls.
module i2c_init_sequencer
  import i2c_init_sequencer_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 12_000_000,
  parameter logic [6:0]  DEVICE_ADDR   = 7'h10,
  parameter int unsigned ROM_DEPTH     = 32,
  parameter string       ROM_FILE      = "",
  parameter int unsigned DELAY_UNIT_US = 1000,
  parameter int unsigned MAX_POLLS     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  i2c_init_sequencer_if.master         bus,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [$clog2(ROM_DEPTH)-1:0] err_index
);

  localparam int unsigned PC_W         = $clog2(ROM_DEPTH);
  localparam int unsigned CPU_RAW      = CLK_HZ / 1_000_000 * DELAY_UNIT_US;
  localparam int unsigned CYC_PER_UNIT = (CPU_RAW == 0) ? 1 : CPU_RAW;
  localparam int unsigned PRESC_W      = $clog2(CYC_PER_UNIT + 1);
  localparam int unsigned POLL_W       = $clog2(MAX_POLLS + 1);

  localparam logic [2:0]  OP_WRITE = 3'b000;
  localparam logic [2:0]  OP_DELAY = 3'b001;
  localparam logic [2:0]  OP_READ  = 3'b010;
  localparam logic [2:0]  OP_END   = 3'b111;
  localparam logic [15:0] END_WORD = 16'hE000;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SEND, S_RDWAIT, S_DELAY, S_DONE, S_ERR
  } state_t;

  logic [15:0]        rom [ROM_DEPTH];
  logic [15:0]        rom_q;
  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [POLL_W-1:0]  polls;
  logic [12:0]        units_left;
  logic [PRESC_W-1:0] presc;
  logic               retry;
  logic               last_pc;

  // ROM contents: all END until written.
  initial begin
    for (int i = 0; i < int'(ROM_DEPTH); i++) rom[i] = END_WORD;
  end

  assign bus.ctl_addr = DEVICE_ADDR;
  assign last_pc      = (pc == PC_W'(ROM_DEPTH - 1));

  // Synchronous ROM read; the word addressed in FETCH is valid in DECODE.
  always_ff @(posedge clk) begin
    rom_q <= rom[pc];
  end

  // Sequencer FSM with registered bus and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pc            <= '0;
      polls         <= '0;
      units_left    <= '0;
      presc         <= '0;
      retry         <= 1'b0;
      bus.ctl_valid <= 1'b0;
      bus.ctl_mode  <= WRITE_8BIT_REGISTER;
      bus.ctl_data  <= '0;
      bus.rd_ready  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_index     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
            polls <= '0;
            retry <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
            busy  <= 1'b1;
          end
        end

        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          case (rom_q[15:13])
            OP_WRITE, OP_READ: begin
              state         <= S_SEND;
              bus.ctl_valid <= 1'b1;
              bus.ctl_mode  <= (rom_q[15:13] == OP_READ) ? READ_8BIT : WRITE_8BIT_REGISTER;
              bus.ctl_data  <= rom_q[7:0];
            end
            OP_DELAY: begin
              if (rom_q[12:0] == 13'd0) begin
                // Zero-length delay just steps to the next entry.
                if (last_pc) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                end else begin
                  pc    <= pc + 1'b1;
                  state <= S_FETCH;
                end
              end else begin
                state      <= S_DELAY;
                units_left <= rom_q[12:0];
                presc      <= PRESC_W'(CYC_PER_UNIT - 1);
                retry      <= 1'b0;
              end
            end
            OP_END: begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
            default: begin
              state     <= S_ERR;
              error     <= 1'b1;
              busy      <= 1'b0;
              err_index <= pc;
            end
          endcase
        end

        S_SEND: begin
          if (bus.ctl_valid && bus.ctl_ready) begin
            bus.ctl_valid <= 1'b0;
            if (bus.ctl_mode == READ_8BIT) begin
              state        <= S_RDWAIT;
              bus.rd_ready <= 1'b1;
            end else if (last_pc) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end
        end

        S_RDWAIT: begin
          // ctl_data still holds the expected byte of this READ_EXPECT entry.
          if (bus.rd_valid && bus.rd_ready) begin
            bus.rd_ready <= 1'b0;
            if (bus.rd_data == bus.ctl_data) begin
              polls <= '0;
              if (last_pc) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                pc    <= pc + 1'b1;
                state <= S_FETCH;
              end
            end else if ((32'(polls) + 32'd1) < MAX_POLLS) begin
              polls      <= polls + 1'b1;
              state      <= S_DELAY;
              units_left <= 13'd1;
              presc      <= PRESC_W'(CYC_PER_UNIT - 1);
              retry      <= 1'b1;
            end else begin
              state     <= S_ERR;
              error     <= 1'b1;
              busy      <= 1'b0;
              err_index <= pc;
            end
          end
        end

        S_DELAY: begin
          if (presc == '0) begin
            if (units_left == 13'd1) begin
              if (retry) begin
                state         <= S_SEND;
                bus.ctl_valid <= 1'b1;
                retry         <= 1'b0;
              end else if (last_pc) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                pc    <= pc + 1'b1;
                state <= S_FETCH;
              end
            end else begin
              units_left <= units_left - 13'd1;
              presc      <= PRESC_W'(CYC_PER_UNIT - 1);
            end
          end else begin
            presc <= presc - 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
